// File: rtl/fu_complete_arb.sv
// fu_complete_arb
//   Collects completion pulses from FU_COUNT functional units and funnels them
//   into the single ROB completion port. FUs cannot be stalled, so each FU
//   owns a DEPTH-entry FIFO; a round-robin arbiter drains one entry per
//   valid/ready handshake.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   fu_out_valid[i]       : completion pulse from FU i (pushes FIFO i)
//   fu_out_inst_id[i]     : instruction id carried by that pulse
//   fu_almost_full[i]     : FIFO i holds >= DEPTH-1 entries
//   rob_complete_valid    : a completion is presented to the ROB
//   rob_complete_ready    : ROB accepts the presented completion
//   rob_complete_inst_id  : presented id (0 when not valid)
//   rob_complete_fu       : source FU of the presented id (0 when not valid)
//   overflow_err          : sticky; a completion was dropped on a full FIFO
module fu_complete_arb #(
  parameter int INST_ID_BITS = 6,
  parameter int FU_COUNT     = 4,
  parameter int DEPTH        = 4,
  localparam int FU_W        = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [FU_COUNT-1:0]                    fu_out_valid,
  input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]  fu_out_inst_id,
  output logic [FU_COUNT-1:0]                    fu_almost_full,
  output logic                                   rob_complete_valid,
  input  logic                                   rob_complete_ready,
  output logic [INST_ID_BITS-1:0]                rob_complete_inst_id,
  output logic [FU_W-1:0]                        rob_complete_fu,
  output logic                                   overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_ID_BITS-1:0] mem    [FU_COUNT][DEPTH];
  logic [PTR_W-1:0]        rd_ptr [FU_COUNT];
  logic [PTR_W-1:0]        wr_ptr [FU_COUNT];
  logic [CNT_W-1:0]        count  [FU_COUNT];
  logic [FU_W-1:0]         rr_ptr;

  logic [FU_W-1:0]         grant;
  logic [FU_W-1:0]         cand;
  logic                    any_valid;
  logic                    hs;
  logic [FU_COUNT-1:0]     pop;
  logic [FU_COUNT-1:0]     accept;
  logic [FU_COUNT-1:0]     drop;

  // Round-robin search: iterate from the farthest offset down to rr_ptr so
  // the last hit (closest to rr_ptr) wins.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned k = FU_COUNT; k > 0; k--) begin
      cand = FU_W'((32'(rr_ptr) + k - 1) % 32'(FU_COUNT));
      if (count[cand] != '0) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign hs                   = any_valid & rob_complete_ready;
  assign rob_complete_valid   = any_valid;
  assign rob_complete_fu      = any_valid ? grant : '0;
  assign rob_complete_inst_id = any_valid ? mem[grant][rd_ptr[grant]] : '0;

  // A pop frees the slot first, so a full FIFO still accepts a same-cycle push.
  always_comb begin
    pop    = '0;
    accept = '0;
    drop   = '0;
    for (int unsigned i = 0; i < FU_COUNT; i++) begin
      pop[i]            = hs && (grant == FU_W'(i));
      accept[i]         = fu_out_valid[i] && ((count[i] != CNT_W'(DEPTH)) || pop[i]);
      drop[i]           = fu_out_valid[i] && !accept[i];
      fu_almost_full[i] = (count[i] >= CNT_W'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      overflow_err <= 1'b0;
      for (int unsigned i = 0; i < FU_COUNT; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (hs) begin
        rr_ptr <= (grant == FU_W'(FU_COUNT - 1)) ? '0 : grant + FU_W'(1);
      end
      if (|drop) begin
        overflow_err <= 1'b1;
      end
      for (int unsigned i = 0; i < FU_COUNT; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(accept[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Storage needs no reset; occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < FU_COUNT; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= fu_out_inst_id[i];
    end
  end

endmodule

// File: tb/tb_fu_complete_arb.sv
module tb_fu_complete_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       fu_out_valid;
  logic [3:0][5:0]  fu_out_inst_id;
  logic [3:0]       fu_almost_full;
  logic             rob_complete_valid;
  logic             rob_complete_ready;
  logic [5:0]       rob_complete_inst_id;
  logic [1:0]       rob_complete_fu;
  logic             overflow_err;

  int errors = 0;
  int checks = 0;

  fu_complete_arb #(
    .INST_ID_BITS(6),
    .FU_COUNT(4),
    .DEPTH(4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .fu_out_valid         (fu_out_valid),
    .fu_out_inst_id       (fu_out_inst_id),
    .fu_almost_full       (fu_almost_full),
    .rob_complete_valid   (rob_complete_valid),
    .rob_complete_ready   (rob_complete_ready),
    .rob_complete_inst_id (rob_complete_inst_id),
    .rob_complete_fu      (rob_complete_fu),
    .overflow_err         (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [23:0] ids;   // {id3, id2, id1, id0}
    logic        rdy;
    logic        ev;
    logic [5:0]  eid;
    logic [1:0]  efu;
    logic [3:0]  eaf;
    logic        eovf;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] v, logic [23:0] ids, logic rdy,
                              logic ev, logic [5:0] eid, logic [1:0] efu,
                              logic [3:0] eaf, logic eovf);
    vec_t t;
    t.rst = r; t.v = v; t.ids = ids; t.rdy = rdy;
    t.ev = ev; t.eid = eid; t.efu = efu; t.eaf = eaf; t.eovf = eovf;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string tag, logic ev, logic [5:0] eid, logic [1:0] efu,
                           logic [3:0] eaf, logic eovf);
    check({tag, ".valid"}, 32'(rob_complete_valid), 32'(ev));
    check({tag, ".id"},    32'(rob_complete_inst_id), 32'(eid));
    check({tag, ".fu"},    32'(rob_complete_fu), 32'(efu));
    check({tag, ".af"},    32'(fu_almost_full), 32'(eaf));
    check({tag, ".ovf"},   32'(overflow_err), 32'(eovf));
  endtask

  localparam int NV = 26;
  vec_t tbl [NV];

  initial begin
    rst = 1'b1;
    fu_out_valid = '0;
    fu_out_inst_id = '0;
    rob_complete_ready = 1'b0;

    // Each row: inputs applied before an edge, expected outputs after it.
    // reset with pushes on every FU
    tbl[0]  = mk(1, 4'hF, {6'h04, 6'h03, 6'h02, 6'h01}, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    tbl[1]  = mk(1, 4'hF, {6'h04, 6'h03, 6'h02, 6'h01}, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    tbl[2]  = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    tbl[3]  = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    // latency: single push on FU2
    tbl[4]  = mk(0, 4'b0100, {6'h00, 6'h15, 6'h00, 6'h00}, 1, 1, 6'h15, 2'd2, 4'h0, 0);
    tbl[5]  = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);   // rr_ptr -> 3
    tbl[6]  = mk(0, 4'b1000, {6'h3A, 6'h00, 6'h00, 6'h00}, 1, 1, 6'h3A, 2'd3, 4'h0, 0);
    tbl[7]  = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);   // rr_ptr -> 0
    // round robin over all four FUs
    tbl[8]  = mk(0, 4'hF, {6'h13, 6'h12, 6'h11, 6'h10}, 1, 1, 6'h10, 2'd0, 4'h0, 0);
    tbl[9]  = mk(0, 4'h0, 24'h0, 1, 1, 6'h11, 2'd1, 4'h0, 0);
    tbl[10] = mk(0, 4'h0, 24'h0, 1, 1, 6'h12, 2'd2, 4'h0, 0);
    tbl[11] = mk(0, 4'h0, 24'h0, 1, 1, 6'h13, 2'd3, 4'h0, 0);
    tbl[12] = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    tbl[13] = mk(0, 4'b1010, {6'h33, 6'h00, 6'h31, 6'h00}, 1, 1, 6'h31, 2'd1, 4'h0, 0);
    tbl[14] = mk(0, 4'h0, 24'h0, 1, 1, 6'h33, 2'd3, 4'h0, 0);
    tbl[15] = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    // backpressure on FU1
    tbl[16] = mk(0, 4'b0010, {6'h00, 6'h00, 6'h21, 6'h00}, 0, 1, 6'h21, 2'd1, 4'h0, 0);
    tbl[17] = mk(0, 4'b0010, {6'h00, 6'h00, 6'h22, 6'h00}, 0, 1, 6'h21, 2'd1, 4'h0, 0);
    tbl[18] = mk(0, 4'b0010, {6'h00, 6'h00, 6'h23, 6'h00}, 0, 1, 6'h21, 2'd1, 4'h2, 0);
    tbl[19] = mk(0, 4'h0, 24'h0, 0, 1, 6'h21, 2'd1, 4'h2, 0);
    tbl[20] = mk(0, 4'h0, 24'h0, 1, 1, 6'h22, 2'd1, 4'h0, 0);
    tbl[21] = mk(0, 4'h0, 24'h0, 1, 1, 6'h23, 2'd1, 4'h0, 0);
    tbl[22] = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);
    // reset mid-operation discards pending entries
    tbl[23] = mk(0, 4'b0001, {6'h00, 6'h00, 6'h00, 6'h05}, 0, 1, 6'h05, 2'd0, 4'h0, 0);
    tbl[24] = mk(1, 4'b0001, {6'h00, 6'h00, 6'h00, 6'h06}, 0, 0, 6'h00, 2'd0, 4'h0, 0);
    tbl[25] = mk(0, 4'h0, 24'h0, 1, 0, 6'h00, 2'd0, 4'h0, 0);

    for (int n = 0; n < NV; n++) begin
      rst                = tbl[n].rst;
      fu_out_valid       = tbl[n].v;
      fu_out_inst_id     = tbl[n].ids;
      rob_complete_ready = tbl[n].rdy;
      step();
      check_out($sformatf("vec%0d", n), tbl[n].ev, tbl[n].eid, tbl[n].efu,
                tbl[n].eaf, tbl[n].eovf);
    end

    // Overflow: five pushes into FU0 with ready low; fifth is dropped.
    fu_out_valid = '0; fu_out_inst_id = '0; rob_complete_ready = 1'b0; rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      fu_out_valid = 4'b0001;
      fu_out_inst_id[0] = 6'(k);
      step();
      check($sformatf("ovf.push%0d.err", k), 32'(overflow_err), (k == 5) ? 1 : 0);
      check($sformatf("ovf.push%0d.af", k),  32'(fu_almost_full[0]), (k >= 3) ? 1 : 0);
    end
    fu_out_valid = '0;
    rob_complete_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_out($sformatf("ovf.drain%0d", k), 1'b1, 6'(k), 2'd0,
                (k <= 2) ? 4'h1 : 4'h0, 1'b1);
      step();
    end
    check_out("ovf.empty", 1'b0, 6'h00, 2'd0, 4'h0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("ovf.cleared", 1'b0, 6'h00, 2'd0, 4'h0, 1'b0);

    // Full FIFO with simultaneous push and pop keeps count at DEPTH.
    rob_complete_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fu_out_valid = 4'b0001;
      fu_out_inst_id[0] = 6'h31 + 6'(k);
      step();
    end
    check_out("full.filled", 1'b1, 6'h31, 2'd0, 4'h1, 1'b0);
    fu_out_inst_id[0] = 6'h3F;
    rob_complete_ready = 1'b1;
    step();
    check_out("full.pushpop", 1'b1, 6'h32, 2'd0, 4'h1, 1'b0);
    // Still full: a push without a pop must now be dropped.
    fu_out_inst_id[0] = 6'h2A;
    rob_complete_ready = 1'b0;
    step();
    check_out("full.stillfull", 1'b1, 6'h32, 2'd0, 4'h1, 1'b1);
    fu_out_valid = '0;
    rob_complete_ready = 1'b1;
    begin
      logic [5:0] exp_ids [4];
      exp_ids = '{6'h32, 6'h33, 6'h34, 6'h3F};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("full.drain%0d.valid", k), 32'(rob_complete_valid), 1);
        check($sformatf("full.drain%0d.id", k), 32'(rob_complete_inst_id), 32'(exp_ids[k]));
        step();
      end
    end
    check("full.empty.valid", 32'(rob_complete_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
